video_sync_gen: RTL and testbench
=================================

Name: video_sync_gen

Overview:
Generates PAL or NTSC progressive (288p/240p-style) sync timing from one system clock: HSYNC, VSYNC, active-video window, line counter and field-start strobe. It is the source side of the VSYNC-period format detection path. Its VSYNC falling-edge period is the quantity the detector measures, so PAL and NTSC field periods must fall on opposite sides of `NTSC_PAL_THRESHOLD`. It is also used as a timing master for test patterns and overlays.

Parameters:
- H_TOTAL_PAL, 1728, clocks per line in PAL (64 us at 27 MHz)
- H_TOTAL_NTSC, 1716, clocks per line in NTSC (63.56 us at 27 MHz)
- V_TOTAL_PAL, 312, lines per PAL field
- V_TOTAL_NTSC, 262, lines per NTSC field
- HSYNC_LEN, 127, HSYNC low width in clocks (4.7 us)
- VSYNC_LINES, 3, VSYNC low width in whole lines
- H_ACT_START, 264, first active clock of a line
- H_ACT_LEN, 1440, active clocks per line
- V_ACT_START, 21, first active line
- V_ACT_PAL, 288, active lines in PAL
- V_ACT_NTSC, 240, active lines in NTSC

Ports:
- clk_in, input, 1, system clock (`CLK_FREQ`, 27 MHz)
- rst_in, input, 1, reset; asynchronous, active-high
- enable_in, input, 1, run generator; low holds it idle
- format_sel, input, 1, requested format (`FORMAT_PAL` / `FORMAT_NTSC`)
- hsync_out, output, 1, horizontal sync, active-low
- vsync_out, output, 1, vertical sync, active-low, line-aligned
- active_out, output, 1, high inside active window
- field_start, output, 1, one-clock pulse on each VSYNC falling edge
- line_out, output, 9, current line number (0 to V_TOTAL-1)
- format_out, output, 1, format currently being generated

Behaviour:
- One clock domain (clk_in). Reset is asynchronous, active-high. While rst_in is high, all outputs are forced immediately, with no clock needed:
  - h_cnt=0, v_cnt=0
  - hsync_out=1, vsync_out=1, active_out=0, field_start=0
  - line_out=0, format_out=`FORMAT_NTSC`
- Counters: h_cnt is 11 bits, v_cnt is 9 bits. The active format is fmt_cur.
  - Per-format totals are selected by fmt_cur only.
  - h_cnt wraps at H_TOTAL(fmt)-1. On that wrap, v_cnt increments and itself wraps at V_TOTAL(fmt)-1.
- Format latch: fmt_cur loads format_sel only in two cases:
  - on the field-wrap cycle (h=H_TOTAL-1 and v=V_TOTAL-1);
  - on any cycle with enable_in=0.
  - A format_sel change mid-field is ignored until the next field boundary; a field never mixes formats.
- Idle: with enable_in=0, counters are held at 0 and outputs are held at their reset values. format_out still tracks format_sel.
- Start: the first enabled cycle evaluates state (0,0). This produces a field_start pulse and VSYNC/HSYNC falling edges one cycle later.
- Output decode is registered, so state (h,v) at cycle n appears on the outputs at cycle n+1. This latency is fixed.
  - hsync_out=0 iff h<HSYNC_LEN.
  - vsync_out=0 iff v<VSYNC_LINES.
  - active_out=1 iff H_ACT_START<=h<H_ACT_START+H_ACT_LEN and V_ACT_START<=v<V_ACT_START+V_ACT(fmt).
  - field_start=1 iff h=0 and v=0.
  - line_out=v; format_out=fmt_cur.
- VSYNC and HSYNC falling edges coincide on line 0.
- Field periods:
  - PAL: 1728*312 = 539136 clocks (19.968 ms).
  - NTSC: 1716*262 = 449592 clocks (16.652 ms).
- Enable drop mid-field aborts the field at once. The outputs return to idle on the next cycle, with no partial-field completion.
- Reset mid-field: asynchronous clear. After release, the block restarts from (0,0) on the first enabled cycle, in NTSC or the currently selected format per the enable rule.
- Arithmetic is unsigned. No counter may exceed its total; there are no out-of-range states.

Decomposition:
- Add to the shared `Consts.vh`: the PAL/NTSC H_TOTAL and V_TOTAL values, the sync widths, and the active-window constants. Keep `FORMAT_PAL`, `FORMAT_NTSC`, `TRUE`, `FALSE` and `CLK_FREQ` as already defined there.
- One sub-module is natural: sync_counter. It holds the h/v counters with wrap and format-latch logic, takes H_TOTAL and V_TOTAL as inputs, and drives the enable hold. video_sync_gen instantiates it and adds the registered output decode.

Test Plan:
- Reset, enable_in=1, format_sel=PAL → first field_start one cycle after the first enabled cycle. Successive vsync_out falling edges are 539136 clocks apart. vsync_out stays low for 3*1728 = 5184 clocks.
- format_sel=NTSC → vsync_out falling-edge period 449592. hsync_out falls every 1716 clocks and stays low 127 clocks. line_out runs 0..261 then wraps.
- PAL running, format_sel toggled to NTSC at line 100 → the current field completes at 539136 clocks. The next period is 449592. format_out changes on the field boundary only.
- Active window: count active_out=1 clocks per field → 1440*288 = 414720 (PAL) and 1440*240 = 345600 (NTSC). Active first goes high at line 21, h=264.
- enable_in deasserted at line 50 → next cycle hsync_out=1, vsync_out=1, active_out=0, line_out=0. Re-enable → field_start one cycle after the first enabled cycle.
- rst_in pulsed asynchronously (between clock edges) mid-line → outputs go to reset values before the next clk_in edge. format_out=NTSC while reset is held. After release, timing restarts from line 0.

Source files
------------

// File: rtl/video_sync_gen_pkg.sv
// rtl/video_sync_gen_pkg.sv - shared constants, output bundle type and helpers for the sync generator
package video_sync_gen_pkg;

    localparam logic FORMAT_NTSC = 1'b0;
    localparam logic FORMAT_PAL  = 1'b1;
    localparam logic TRUE        = 1'b1;
    localparam logic FALSE       = 1'b0;
    localparam int   CLK_FREQ    = 27_000_000;

    // Broadcast timing defaults at 27 MHz; the top exposes each as an overridable parameter
    localparam int DEF_H_TOTAL_PAL  = 1728;
    localparam int DEF_H_TOTAL_NTSC = 1716;
    localparam int DEF_V_TOTAL_PAL  = 312;
    localparam int DEF_V_TOTAL_NTSC = 262;
    localparam int DEF_HSYNC_LEN    = 127;
    localparam int DEF_VSYNC_LINES  = 3;
    localparam int DEF_H_ACT_START  = 264;
    localparam int DEF_H_ACT_LEN    = 1440;
    localparam int DEF_V_ACT_START  = 21;
    localparam int DEF_V_ACT_PAL    = 288;
    localparam int DEF_V_ACT_NTSC   = 240;

    localparam int H_CNT_W = 11;
    localparam int V_CNT_W = 9;

    // Everything the generator drives, registered together so all outputs share one latency
    typedef struct packed {
        logic               hsync;
        logic               vsync;
        logic               active;
        logic               field_start;
        logic [V_CNT_W-1:0] line;
        logic               format;
    } sync_out_t;

    // Idle and reset present the same levels: syncs released, no active video
    localparam sync_out_t SYNC_IDLE = '{
        hsync:       1'b1,
        vsync:       1'b1,
        active:      1'b0,
        field_start: 1'b0,
        line:        '0,
        format:      FORMAT_NTSC
    };

    // Half-open window test lo <= val < hi
    function automatic logic in_window(input logic [H_CNT_W-1:0] val,
                                       input logic [H_CNT_W-1:0] lo,
                                       input logic [H_CNT_W-1:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/video_sync_gen_counter.sv
// rtl/video_sync_gen_counter.sv - h/v raster counters with field-boundary format latch and enable hold
module sync_counter
    import video_sync_gen_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               enable_in,
    input  logic               format_sel,
    input  logic [H_CNT_W-1:0] h_total,
    input  logic [V_CNT_W-1:0] v_total,
    output logic [H_CNT_W-1:0] h_cnt,
    output logic [V_CNT_W-1:0] v_cnt,
    output logic               fmt_cur
);

    logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic               fmt_cur_q, fmt_cur_d;
    logic               h_last;
    logic               v_last;

    // Advance the raster; the format may only change where a field ends or while idle
    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        fmt_cur_d = fmt_cur_q;
        // >= rather than == so a counter can never run past its total
        h_last    = (h_cnt_q >= (h_total - 11'd1));
        v_last    = (v_cnt_q >= (v_total - 9'd1));
        if (!enable_in) begin
            h_cnt_d   = '0;
            v_cnt_d   = '0;
            fmt_cur_d = format_sel;
        end else if (h_last) begin
            h_cnt_d = '0;
            if (v_last) begin
                v_cnt_d   = '0;
                fmt_cur_d = format_sel;
            end else begin
                v_cnt_d = v_cnt_q + 9'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q + 11'd1;
        end
    end

    // Counter and format state, cleared asynchronously to the NTSC origin
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            fmt_cur_q <= FORMAT_NTSC;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            fmt_cur_q <= fmt_cur_d;
        end
    end

    assign h_cnt   = h_cnt_q;
    assign v_cnt   = v_cnt_q;
    assign fmt_cur = fmt_cur_q;

endmodule

// File: rtl/video_sync_gen.sv
// rtl/video_sync_gen.sv - PAL/NTSC progressive sync timing generator with registered output decode
module video_sync_gen
    import video_sync_gen_pkg::*;
#(
    parameter int H_TOTAL_PAL  = DEF_H_TOTAL_PAL,
    parameter int H_TOTAL_NTSC = DEF_H_TOTAL_NTSC,
    parameter int V_TOTAL_PAL  = DEF_V_TOTAL_PAL,
    parameter int V_TOTAL_NTSC = DEF_V_TOTAL_NTSC,
    parameter int HSYNC_LEN    = DEF_HSYNC_LEN,
    parameter int VSYNC_LINES  = DEF_VSYNC_LINES,
    parameter int H_ACT_START  = DEF_H_ACT_START,
    parameter int H_ACT_LEN    = DEF_H_ACT_LEN,
    parameter int V_ACT_START  = DEF_V_ACT_START,
    parameter int V_ACT_PAL    = DEF_V_ACT_PAL,
    parameter int V_ACT_NTSC   = DEF_V_ACT_NTSC
)
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               enable_in,
    input  logic               format_sel,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               active_out,
    output logic               field_start,
    output logic [V_CNT_W-1:0] line_out,
    output logic               format_out
);

    localparam logic [H_CNT_W-1:0] HT_PAL   = H_CNT_W'(H_TOTAL_PAL);
    localparam logic [H_CNT_W-1:0] HT_NTSC  = H_CNT_W'(H_TOTAL_NTSC);
    localparam logic [V_CNT_W-1:0] VT_PAL   = V_CNT_W'(V_TOTAL_PAL);
    localparam logic [V_CNT_W-1:0] VT_NTSC  = V_CNT_W'(V_TOTAL_NTSC);
    localparam logic [H_CNT_W-1:0] HS_LEN   = H_CNT_W'(HSYNC_LEN);
    localparam logic [V_CNT_W-1:0] VS_LINES = V_CNT_W'(VSYNC_LINES);
    localparam logic [H_CNT_W-1:0] H_ACT_LO = H_CNT_W'(H_ACT_START);
    localparam logic [H_CNT_W-1:0] H_ACT_HI = H_CNT_W'(H_ACT_START + H_ACT_LEN);
    localparam logic [H_CNT_W-1:0] V_ACT_LO = H_CNT_W'(V_ACT_START);
    localparam logic [V_CNT_W-1:0] VA_PAL   = V_CNT_W'(V_ACT_PAL);
    localparam logic [V_CNT_W-1:0] VA_NTSC  = V_CNT_W'(V_ACT_NTSC);

    logic [H_CNT_W-1:0] h_total;
    logic [V_CNT_W-1:0] v_total;
    logic [V_CNT_W-1:0] v_act_len;
    logic [H_CNT_W-1:0] v_act_hi;
    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;
    logic               fmt_cur;
    sync_out_t          out_d, out_q;

    // Totals and active height follow the latched format, never the raw request
    always_comb begin
        h_total   = HT_NTSC;
        v_total   = VT_NTSC;
        v_act_len = VA_NTSC;
        if (fmt_cur == FORMAT_PAL) begin
            h_total   = HT_PAL;
            v_total   = VT_PAL;
            v_act_len = VA_PAL;
        end
        v_act_hi = V_ACT_LO + {2'b00, v_act_len};
    end

    sync_counter u_sync_counter (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .enable_in  (enable_in),
        .format_sel (format_sel),
        .h_total    (h_total),
        .v_total    (v_total),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .fmt_cur    (fmt_cur)
    );

    // Decode the current raster position; idle cycles present released syncs
    always_comb begin
        out_d        = SYNC_IDLE;
        out_d.format = fmt_cur;
        if (enable_in) begin
            out_d.hsync       = (h_cnt >= HS_LEN);
            out_d.vsync       = (v_cnt >= VS_LINES);
            out_d.active      = in_window(h_cnt, H_ACT_LO, H_ACT_HI) &&
                                in_window({2'b00, v_cnt}, V_ACT_LO, v_act_hi);
            out_d.field_start = (h_cnt == '0) && (v_cnt == '0);
            out_d.line        = v_cnt;
        end
    end

    // One register stage for every output so their mutual alignment is exact
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_q <= SYNC_IDLE;
        end else begin
            out_q <= out_d;
        end
    end

    assign hsync_out   = out_q.hsync;
    assign vsync_out   = out_q.vsync;
    assign active_out  = out_q.active;
    assign field_start = out_q.field_start;
    assign line_out    = out_q.line;
    assign format_out  = out_q.format;

endmodule

// File: tb/tb_video_sync_gen.sv
// tb/tb_video_sync_gen.sv - scoreboard bench for video_sync_gen on a scaled-down raster
module tb_video_sync_gen;
    import video_sync_gen_pkg::*;

    localparam int HT_P = 40;
    localparam int HT_N = 36;
    localparam int VT_P = 12;
    localparam int VT_N = 10;
    localparam int HS_L = 5;
    localparam int VS_L = 3;
    localparam int HA_S = 8;
    localparam int HA_L = 20;
    localparam int VA_S = 2;
    localparam int VA_P = 8;
    localparam int VA_N = 6;

    localparam logic [13:0] RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 9'd0, FORMAT_NTSC};

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       fsel;
    logic       hsync_out;
    logic       vsync_out;
    logic       active_out;
    logic       field_start;
    logic [8:0] line_out;
    logic       format_out;

    video_sync_gen #(
        .H_TOTAL_PAL (HT_P), .H_TOTAL_NTSC (HT_N),
        .V_TOTAL_PAL (VT_P), .V_TOTAL_NTSC (VT_N),
        .HSYNC_LEN   (HS_L), .VSYNC_LINES  (VS_L),
        .H_ACT_START (HA_S), .H_ACT_LEN    (HA_L),
        .V_ACT_START (VA_S), .V_ACT_PAL    (VA_P),
        .V_ACT_NTSC  (VA_N)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .enable_in   (en),
        .format_sel  (fsel),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .active_out  (active_out),
        .field_start (field_start),
        .line_out    (line_out),
        .format_out  (format_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [13:0] sb_q[$];
    int   m_h, m_v;
    logic m_fmt;
    int   cyc;

    logic prev_vs, prev_hs;
    bit   vf_valid, hf_valid, fs_armed;
    int   last_vf, last_hf, fs_cyc;
    int   act_cnt, vlow_cnt, hlow_cnt;
    int   per_q[$], act_q[$], vlow_q[$], hper_q[$], hlow_q[$], fact_q[$];

    function automatic logic [13:0] obs_vec();
        return {hsync_out, vsync_out, active_out, field_start, line_out, format_out};
    endfunction

    task automatic clear_meas();
        per_q.delete(); act_q.delete(); vlow_q.delete();
        hper_q.delete(); hlow_q.delete(); fact_q.delete();
        vf_valid = 0; hf_valid = 0; fs_armed = 0;
    endtask

    task automatic measure();
        if (prev_vs && !vsync_out) begin
            if (vf_valid) begin
                per_q.push_back(cyc - last_vf);
                act_q.push_back(act_cnt);
            end
            vf_valid = 1; last_vf = cyc; act_cnt = 0; vlow_cnt = 0;
        end
        if (!vsync_out) vlow_cnt++;
        if (!prev_vs && vsync_out && vf_valid) vlow_q.push_back(vlow_cnt);
        if (active_out) act_cnt++;
        if (prev_hs && !hsync_out) begin
            if (hf_valid) hper_q.push_back(cyc - last_hf);
            hf_valid = 1; last_hf = cyc; hlow_cnt = 0;
        end
        if (!hsync_out) hlow_cnt++;
        if (!prev_hs && hsync_out && hf_valid) hlow_q.push_back(hlow_cnt);
        if (field_start) begin
            fs_cyc = cyc; fs_armed = 1;
        end
        if (active_out && fs_armed) begin
            fact_q.push_back(cyc - fs_cyc); fs_armed = 0;
        end
        prev_vs = vsync_out;
        prev_hs = hsync_out;
    endtask

    // Drive one cycle of stimulus, predict the outputs it produces, then compare after the edge
    task automatic step(input logic r, input logic e, input logic f);
        logic [13:0] ex;
        int ht, vt, va;
        rst = r; en = e; fsel = f;
        if (r) begin
            ex = RST_VEC;
            m_h = 0; m_v = 0; m_fmt = FORMAT_NTSC;
        end else if (!e) begin
            ex = {1'b1, 1'b1, 1'b0, 1'b0, 9'd0, m_fmt};
            m_h = 0; m_v = 0; m_fmt = f;
        end else begin
            ht = (m_fmt == FORMAT_PAL) ? HT_P : HT_N;
            vt = (m_fmt == FORMAT_PAL) ? VT_P : VT_N;
            va = (m_fmt == FORMAT_PAL) ? VA_P : VA_N;
            ex = {(m_h >= HS_L), (m_v >= VS_L),
                  (m_h >= HA_S && m_h < HA_S + HA_L && m_v >= VA_S && m_v < VA_S + va),
                  (m_h == 0 && m_v == 0), 9'(m_v), m_fmt};
            if (m_h == ht - 1) begin
                m_h = 0;
                if (m_v == vt - 1) begin
                    m_v = 0; m_fmt = f;
                end else begin
                    m_v++;
                end
            end else begin
                m_h++;
            end
        end
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        cyc++;
        check("out_vec", obs_vec(), sb_q.pop_front());
        measure();
    endtask

    task automatic run_vfalls(input int n, input logic f, input int budget);
        int k = 0;
        while (per_q.size() < n && k < budget) begin
            step(1'b0, 1'b1, f);
            k++;
        end
        check("vfall_count", per_q.size(), n);
    endtask

    task automatic run_to_line(input int ln, input logic f, input int budget);
        int k = 0;
        while (line_out != 9'(ln) && k < budget) begin
            step(1'b0, 1'b1, f);
            k++;
        end
        check("reach_line", line_out, ln);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; fsel = FORMAT_PAL;
        m_h = 0; m_v = 0; m_fmt = FORMAT_NTSC; cyc = 0;
        prev_vs = 1'b1; prev_hs = 1'b1;
        act_cnt = 0; vlow_cnt = 0; hlow_cnt = 0; last_vf = 0; last_hf = 0; fs_cyc = 0;
        clear_meas();

        // Reset applies before any clock edge
        #2;
        check("rst_no_clk", obs_vec(), RST_VEC);
        step(1'b1, 1'b0, FORMAT_PAL);
        step(1'b1, 1'b0, FORMAT_PAL);

        // Idle: outputs held, format_out follows the request
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, FORMAT_PAL);
        check("idle_fmt_track", format_out, FORMAT_PAL);

        // PAL from start: field_start and sync falls one cycle after the first enabled cycle
        clear_meas();
        step(1'b0, 1'b1, FORMAT_PAL);
        check("start_fs", field_start, 1'b1);
        check("start_vs", vsync_out, 1'b0);
        check("start_hs", hsync_out, 1'b0);
        run_vfalls(2, FORMAT_PAL, 1200);
        check("pal_period0", per_q[0], HT_P * VT_P);
        check("pal_period1", per_q[1], HT_P * VT_P);
        check("pal_active", act_q[0], HA_L * VA_P);
        check("pal_vs_low", vlow_q[0], VS_L * HT_P);
        check("pal_first_act", fact_q[0], VA_S * HT_P + HA_S);

        // Switch to NTSC mid-field: PAL field completes, next field is NTSC
        per_q.delete(); act_q.delete(); hper_q.delete(); hlow_q.delete();
        run_to_line(5, FORMAT_PAL, 600);
        run_vfalls(2, FORMAT_NTSC, 1200);
        check("sw_period_pal", per_q[0], HT_P * VT_P);
        check("sw_period_ntsc", per_q[1], HT_N * VT_N);
        check("sw_act_pal", act_q[0], HA_L * VA_P);
        check("sw_act_ntsc", act_q[1], HA_L * VA_N);
        check("ntsc_fmt_out", format_out, FORMAT_NTSC);
        check("ntsc_hs_period", hper_q[hper_q.size() - 1], HT_N);
        check("ntsc_hs_low", hlow_q[hlow_q.size() - 1], HS_L);

        // Enable drop mid-field aborts at once; re-enable restarts at (0,0)
        run_to_line(5, FORMAT_NTSC, 400);
        step(1'b0, 1'b0, FORMAT_NTSC);
        check("drop_vec", obs_vec(), {1'b1, 1'b1, 1'b0, 1'b0, 9'd0, FORMAT_NTSC});
        step(1'b0, 1'b1, FORMAT_NTSC);
        check("reen_fs", field_start, 1'b1);

        // Asynchronous reset mid-line, then restart in NTSC though PAL is requested
        run_to_line(3, FORMAT_NTSC, 400);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, FORMAT_NTSC);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_async", obs_vec(), RST_VEC);
        step(1'b1, 1'b1, FORMAT_PAL);
        step(1'b1, 1'b1, FORMAT_PAL);
        check("rst_fmt_ntsc", format_out, FORMAT_NTSC);
        clear_meas();
        prev_vs = vsync_out; prev_hs = hsync_out;
        step(1'b0, 1'b1, FORMAT_PAL);
        check("rel_fs", field_start, 1'b1);
        check("rel_line", line_out, 0);
        run_vfalls(1, FORMAT_PAL, 500);
        check("rel_period_ntsc", per_q[0], HT_N * VT_N);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, FORMAT_PAL);
        check("rel_fmt_pal", format_out, FORMAT_PAL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
